// File: rtl/bcd_updown_counter.sv
// rtl/bcd_updown_counter.sv - multi-digit BCD up/down counter with load, clear, wrap/saturate
//
// Ports:
//   clk       rising-edge clock
//   reset_n   asynchronous active-low reset
//   clr       synchronous clear to zero (highest priority)
//   load      synchronous parallel load of load_val
//   load_val  BCD load value, digit i = bits [4i+3:4i]
//   en        count enable
//   up        1 = count up, 0 = count down
//   q         registered BCD count, digit 0 least significant
//   tc        combinational terminal count (all 9s going up, zero going down)
//   wrap      registered pulse on boundary crossing or saturation hit
//   load_err  registered pulse when a loaded digit was above 9

module bcd_updown_counter #(
    parameter int DIGITS   = 2,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  en,
    input  logic                  up,
    output logic [4*DIGITS-1:0]   q,
    output logic                  tc,
    output logic                  wrap,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0] count_next;
    logic [W-1:0] load_clean;
    logic         all_nine;
    logic         all_zero;
    logic         load_bad;
    logic         chain;

    // One pass over the decades builds the boundary flags, the sanitised
    // load value and the next count. 'chain' is the carry (up) or borrow
    // (down) rippling from digit 0 upward.
    always_comb begin
        all_nine   = 1'b1;
        all_zero   = 1'b1;
        load_bad   = 1'b0;
        load_clean = '0;
        count_next = '0;
        chain      = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (q[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (q[4*i +: 4] != 4'd0) all_zero = 1'b0;

            if (load_val[4*i +: 4] > 4'd9) begin
                load_bad             = 1'b1;
                load_clean[4*i +: 4] = 4'd0;
            end else begin
                load_clean[4*i +: 4] = load_val[4*i +: 4];
            end

            // A corrupted digit is scrubbed to 0 on any count and stops
            // the ripple, so digits above it hold this cycle.
            if (q[4*i +: 4] > 4'd9) begin
                count_next[4*i +: 4] = 4'd0;
                chain                = 1'b0;
            end else if (!chain) begin
                count_next[4*i +: 4] = q[4*i +: 4];
            end else if (up) begin
                if (q[4*i +: 4] == 4'd9) begin
                    count_next[4*i +: 4] = 4'd0;
                end else begin
                    count_next[4*i +: 4] = q[4*i +: 4] + 4'd1;
                    chain                = 1'b0;
                end
            end else begin
                if (q[4*i +: 4] == 4'd0) begin
                    count_next[4*i +: 4] = 4'd9;
                end else begin
                    count_next[4*i +: 4] = q[4*i +: 4] - 4'd1;
                    chain                = 1'b0;
                end
            end
        end
    end

    assign tc = up ? all_nine : all_zero;

    // At the boundary the ripple already yields the wrapped value
    // (all 9s -> 0 going up, 0 -> all 9s going down), so wrap mode just
    // takes count_next and saturate mode holds.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q        <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
            if (clr) begin
                q <= '0;
            end else if (load) begin
                q        <= load_clean;
                load_err <= load_bad;
            end else if (en) begin
                if (tc) begin
                    wrap <= 1'b1;
                    if (!SATURATE) q <= count_next;
                end else begin
                    q <= count_next;
                end
            end
        end
    end

endmodule
